// File: rtl/lcd_write_sequencer.sv
// Nios II multi-cycle custom instruction that performs one HD44780 write per issue.
// It owns the RS/RW/E timing and the execution wait. Define LCD_INIT_EN to add the power-up init sequence.
module lcd_write_sequencer #(
  parameter int T_SETUP     = 2,
  parameter int T_EN_HIGH   = 12,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000,
  parameter int T_POWERUP   = 750000,
  parameter int CNT_W       = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic [31:0] result,
  output logic        done,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data,
  output logic        lcd_en
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC,
    DONE
`ifdef LCD_INIT_EN
    , INIT_WAIT
`endif
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             accept;
  logic             exec_long;
  logic             lcd_en_next;
  logic             done_next;

`ifdef LCD_INIT_EN
  logic [2:0] init_idx, init_idx_next;
  logic       init_active, init_active_next;
  logic       init_load;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_byte = 8'h38;
      3'd3:             init_byte = 8'h0C;
      3'd4:             init_byte = 8'h06;
      default:          init_byte = 8'h01;
    endcase
  endfunction
`endif

  // The upper operand bits carry nothing, and T_POWERUP is only consumed by the init build.
  logic unused_ok;
  assign unused_ok = ^{dataa[31:9], CNT_W'(T_POWERUP)};

  assign lcd_rw = 1'b0;

  // Clear Display (0x01) and Return Home (0x02/0x03) need the long execution time.
  assign exec_long = !lcd_rs && (lcd_data[7:1] == 7'd0);

  // NOTE: every signal that this block assigns gets a default first. Otherwise a path that
  // skips the assignment infers a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
`ifdef LCD_INIT_EN
    init_load        = 1'b0;
    init_idx_next    = init_idx;
    init_active_next = init_active;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SETUP;
          cnt_next   = CNT_W'(T_SETUP - 1);
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_next = PULSE;
          cnt_next   = CNT_W'(T_EN_HIGH - 1);
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_next = HOLD;
          cnt_next   = CNT_W'(T_HOLD - 1);
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_next = EXEC;
          cnt_next   = exec_long ? CNT_W'(T_EXEC_LONG - 1) : CNT_W'(T_EXEC - 1);
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      EXEC: begin
        if (cnt == '0) begin
`ifdef LCD_INIT_EN
          // Init writes chain straight into the next write and never report done.
          if (init_active) begin
            if (init_idx == 3'd5) begin
              state_next       = IDLE;
              init_active_next = 1'b0;
            end else begin
              init_load     = 1'b1;
              init_idx_next = init_idx + 3'd1;
              state_next    = SETUP;
              cnt_next      = CNT_W'(T_SETUP - 1);
            end
          end else begin
            state_next = DONE;
          end
`else
          state_next = DONE;
`endif
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      DONE: state_next = IDLE;
`ifdef LCD_INIT_EN
      INIT_WAIT: begin
        if (cnt == CNT_W'(T_POWERUP - 1)) begin
          init_load  = 1'b1;
          state_next = SETUP;
          cnt_next   = CNT_W'(T_SETUP - 1);
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // E and done are registered from the next state, so they change cleanly on a clock edge.
  always_comb begin
    lcd_en_next = (state_next == PULSE);
    done_next   = (state_next == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register then samples
  // the values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
`ifdef LCD_INIT_EN
      state       <= INIT_WAIT;
      init_idx    <= 3'd0;
      init_active <= 1'b1;
`else
      state       <= IDLE;
`endif
      cnt         <= '0;
      lcd_en      <= 1'b0;
      done        <= 1'b0;
      lcd_rs      <= 1'b0;
      lcd_data    <= 8'h00;
      result      <= 32'h0;
    end else if (clk_en) begin
      state  <= state_next;
      cnt    <= cnt_next;
      lcd_en <= lcd_en_next;
      done   <= done_next;
      if (accept) begin
        lcd_rs   <= dataa[8];
        lcd_data <= dataa[7:0];
        result   <= {23'b0, dataa[8:0]};
      end
`ifdef LCD_INIT_EN
      init_idx    <= init_idx_next;
      init_active <= init_active_next;
      if (init_load) begin
        lcd_rs   <= 1'b0;
        lcd_data <= init_byte(init_idx_next);
      end
`endif
    end
  end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Self-checking bench for lcd_write_sequencer. A transaction-level model predicts E, done and the bus per enabled cycle.
// Stimulus is randomized: clk_en patterns, operands and stray start strobes.
module tb_lcd_write_sequencer;

  localparam int TS  = 2;
  localparam int TE  = 3;
  localparam int TH  = 2;
  localparam int TX  = 5;
  localparam int TXL = 20;
  localparam int TP  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] result;
  logic        done;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_data;
  logic        lcd_en;

  int errors = 0;
  int checks = 0;

  lcd_write_sequencer #(
    .T_SETUP    (TS),
    .T_EN_HIGH  (TE),
    .T_HOLD     (TH),
    .T_EXEC     (TX),
    .T_EXEC_LONG(TXL),
    .T_POWERUP  (TP),
    .CNT_W      (20)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .clk_en  (clk_en),
    .start   (start),
    .dataa   (dataa),
    .result  (result),
    .done    (done),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_data(lcd_data),
    .lcd_en  (lcd_en)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Enabled cycles from acceptance to done, inclusive of the done cycle.
  function automatic int latency(input logic [8:0] cmd);
    int texec;
    texec = (!cmd[8] && cmd[7:1] == 7'd0) ? TXL : TX;
    return TS + TE + TH + texec + 1;
  endfunction

  // Called right after a negedge. mode: 0 clk_en high, 1 alternating, 2 random.
  // noise: 0 none, 1 start held after acceptance, 2 random stray starts.
  task automatic run_txn(input logic [31:0] d, input int mode, input int noise);
    int lat;
    int n;
    int zeros;
    bit acc;
    bit en;
    bit exp_en;
    lat   = latency(d[8:0]);
    n     = 0;
    zeros = 0;
    acc   = 1'b0;
    for (int cyc = 0; cyc < 4 * lat + 20 && n < lat + 1; cyc++) begin
      case (mode)
        0: en = 1'b1;
        1: en = cyc[0];
        default: begin
          en = 1'($urandom_range(0, 1));
          if (zeros >= 2) en = 1'b1;
        end
      endcase
      zeros  = en ? 0 : zeros + 1;
      clk_en = en;
      if (!acc) begin
        start = 1'b1;
        dataa = d;
      end else if (noise == 1 || (noise == 2 && $urandom_range(0, 2) == 0)) begin
        start      = 1'b1;
        dataa      = $urandom;
        dataa[8:0] = 9'h155;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      if (en) begin
        if (!acc) begin
          acc = 1'b1;
          n   = 1;
        end else begin
          n++;
        end
      end
      @(negedge clk);
      if (acc) begin
        exp_en = (n - 1 >= TS) && (n - 1 < TS + TE);
        check("lcd_en", {31'b0, lcd_en}, {31'b0, exp_en});
        check("done", {31'b0, done}, {31'b0, (n == lat)});
        check("lcd_rs", {31'b0, lcd_rs}, {31'b0, d[8]});
        check("lcd_data", {24'b0, lcd_data}, {24'b0, d[7:0]});
        check("lcd_rw", {31'b0, lcd_rw}, 32'd0);
        check("result", result, {23'b0, d[8:0]});
      end
    end
    start = 1'b0;
    check("txn_complete", n, lat + 1);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      clk_en = 1'($urandom_range(0, 1));
      start  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("idle_done", {31'b0, done}, 32'd0);
      check("idle_en", {31'b0, lcd_en}, 32'd0);
    end
  endtask

`ifdef LCD_INIT_EN
  task automatic check_init();
    logic [7:0] exp_bytes [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
    int pulses;
    int dones;
    logic prev_en;
    pulses  = 0;
    dones   = 0;
    prev_en = 1'b0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      clk_en = 1'b1;
      start  = (cyc < 90);
      dataa  = 32'h1AA;
      @(posedge clk);
      @(negedge clk);
      if (lcd_en && !prev_en) begin
        if (pulses < 6) begin
          check("init_byte", {24'b0, lcd_data}, {24'b0, exp_bytes[pulses]});
          check("init_rs", {31'b0, lcd_rs}, 32'd0);
        end
        pulses++;
      end
      prev_en = lcd_en;
      if (done) dones++;
    end
    start = 1'b0;
    check("init_pulses", pulses, 6);
    check("init_no_done", dones, 0);
  endtask
`endif

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
`ifdef LCD_INIT_EN
    check_init();
`endif
  endtask

  initial begin
    logic [31:0] d;
    int dones;
    reset  = 1'b1;
    clk_en = 1'b0;
    start  = 1'b0;
    dataa  = 32'h0;
    #12;
    check("rst_en", {31'b0, lcd_en}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_rs", {31'b0, lcd_rs}, 32'd0);
    check("rst_rw", {31'b0, lcd_rw}, 32'd0);
    check("rst_data", {24'b0, lcd_data}, 32'd0);
    check("rst_result", result, 32'd0);
    release_reset();

    // Directed cases: normal, long (Clear/Home), short neighbour, clk_en stretch, stray starts.
    run_txn(32'h141, 0, 0);
    run_txn(32'h001, 0, 0);
    run_txn(32'h003, 0, 0);
    run_txn(32'h004, 0, 0);
    run_txn(32'h141, 1, 0);
    run_txn(32'h141, 0, 1);
    run_txn(32'h155, 0, 0);

    // Reset while E is high: E drops without waiting for a clock, and no done follows.
    @(negedge clk);
    clk_en = 1'b1;
    start  = 1'b1;
    dataa  = 32'h141;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (TS) @(negedge clk);
    check("pulse_before_reset", {31'b0, lcd_en}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_en", {31'b0, lcd_en}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    check("mid_rst_rs", {31'b0, lcd_rs}, 32'd0);
    check("mid_rst_data", {24'b0, lcd_data}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    release_reset();
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("no_done_after_reset", dones, 0);
    run_txn(32'h141, 0, 0);

    // Randomized operands, clk_en patterns, stray starts and idle gaps.
    for (int t = 0; t < 25; t++) begin
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d[8:2] = 7'd0;
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 4));
      run_txn(d, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_write_sequencer.md
Name: lcd_write_sequencer

Overview:
- Multi-cycle Nios II custom instruction that sits between the CPU and the HD44780-compatible character LCD.
- Takes one command or data byte per instruction and owns all LCD bus timing: RS/RW setup, the E pulse, hold, and the controller execution wait.
- Asserts done only once the LCD can accept the next write, so software never bit-bangs E or busy-waits.

Parameters:
- T_SETUP, 2, clk cycles that RS/RW/data are stable before E rises (min 1)
- T_EN_HIGH, 12, clk cycles E is held high (min 1)
- T_HOLD, 2, clk cycles RS/RW/data are held after E falls (min 1)
- T_EXEC, 2000, wait cycles after a normal write (40 us at 50 MHz)
- T_EXEC_LONG, 82000, wait cycles after Clear Display / Return Home (1.64 ms at 50 MHz)
- T_POWERUP, 750000, wait cycles before the init sequence (15 ms); used only with LCD_INIT_EN
- CNT_W, 20, delay counter width; must hold max(all T_*)

Ports:
- clk, input, 1, CPU master clock
- reset, input, 1, asynchronous active-high reset
- clk_en, input, 1, clock qualifier; FSM and counter advance only when high
- start, input, 1, instruction issue strobe
- dataa, input, 32, [8]=RS (0 command, 1 data), [7:0]=byte; [31:9] ignored
- result, output, 32, {23'b0, RS, byte} of the write just completed
- done, output, 1, one-cycle completion pulse
- lcd_rs, output, 1, LCD register select
- lcd_rw, output, 1, LCD read/write; tied 0 (write only)
- lcd_data, output, 8, LCD data bus
- lcd_en, output, 1, LCD enable strobe

Behaviour:
- Reset, asynchronous: state=IDLE (INIT_WAIT if LCD_INIT_EN); counter=0; lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0, result=0, done=0.
- Reset takes effect mid-operation: lcd_en drops the same instant; an in-flight instruction never gets done.
- All registers update only on rising clk with clk_en=1. With clk_en=0, state, counter and outputs hold, including done.
- States and transitions:
  - IDLE: on start=1, latch dataa[8:0] into lcd_rs/lcd_data and result; counter=T_SETUP-1; go to SETUP. start outside IDLE is ignored, no queueing.
  - SETUP: count down; at 0, set lcd_en=1, counter=T_EN_HIGH-1, go to PULSE.
  - PULSE: count down; at 0, set lcd_en=0, counter=T_HOLD-1, go to HOLD.
  - HOLD: count down; at 0, load counter with the exec time minus 1, go to EXEC.
  - Exec time is T_EXEC_LONG when RS=0 and byte[7:1]==7'b0000000 (0x01 Clear, 0x02/0x03 Home); otherwise T_EXEC.
  - EXEC: count down; at 0, go to DONE.
  - DONE: done=1 for exactly one enabled cycle; next state IDLE. lcd_rs/lcd_data keep their last values.
- Latency from the start cycle to the done cycle is T_SETUP+T_EN_HIGH+T_HOLD+Texec+1 enabled cycles.
- start in the DONE cycle is ignored; start in the first IDLE cycle after DONE is accepted (back-to-back).
- lcd_en never glitches; it is registered and high only in PULSE.
- result changes only on acceptance in IDLE and is stable from acceptance through done.

Optional Feature:
- Macro: LCD_INIT_EN.
- Defined:
  - After reset, INIT_WAIT counts T_POWERUP.
  - Then the sequencer issues, with RS=0, the bytes 0x38, 0x38, 0x38, 0x0C, 0x06, 0x01 through SETUP/PULSE/HOLD/EXEC with the normal exec rules (0x01 uses T_EXEC_LONG).
  - Then it enters IDLE. done is never asserted for init writes.
  - start during init is ignored; software polls by retrying.
- Undefined: no init states; reset goes straight to IDLE.

Test Plan:
- Params T_SETUP=2, T_EN_HIGH=3, T_HOLD=2, T_EXEC=5, T_EXEC_LONG=20, clk_en=1; start with dataa=0x141 -> lcd_rs=1, lcd_data=0x41; lcd_en high for exactly 3 cycles, rising 2 cycles after acceptance; done 1 cycle at start+13; result=0x00000141.
- start with dataa=0x001 -> long exec; done at start+28; lcd_rs=0. Repeat with 0x003 -> also +28. Repeat with 0x004 -> +13.
- Toggle clk_en 0/1 every other cycle during the 0x141 write -> identical output sequence, stretched 2x; done held high while clk_en=0 in DONE.
- Second start during PULSE with 0x155 -> ignored; lcd_data stays 0x41. A start on the cycle after done with 0x155 -> accepted.
- Assert reset during PULSE -> lcd_en=0 immediately, no done, all outputs 0. Next start works normally.
- LCD_INIT_EN with T_POWERUP=10 -> after 10 cycles, six E pulses carrying 0x38, 0x38, 0x38, 0x0C, 0x06, 0x01 with RS=0; no done; start during init ignored; first start afterwards completes normally.
